// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for an 8-digit, common-bus 7-segment display.
//
// Scans digits 0..7 in fixed slots of 16 sub-steps, each SCAN_DIV clocks long. Each slot
// has three phases:
//   - Guard: step 0, all anodes off, to avoid ghosting.
//   - On: steps 1..bright.
//   - Off: the rest of the slot.
// New display content arrives over a valid/ready port and is committed only on the last
// cycle of a frame, so a frame never mixes old and new content.
//
// Optional feature: define SEGSCAN_LZB_EN for leading-zero blanking.
//
// Ports
//   CLK         system clock
//   nRST        asynchronous active-low reset
//   upd_valid   update request
//   upd_ready   update accepted when upd_valid & upd_ready
//   upd_data    nibble i = hex value of digit i
//   upd_dp      bit i = decimal point of digit i (1 = lit)
//   digit_en    per-digit enable, sampled at each slot start
//   bright      PWM level 0..15, sampled at each slot start
//   SEG         segments g..a, active-low
//   DP          decimal point, active-low
//   AN          digit anodes, active-low, at most one low
//   frame_tick  one-cycle pulse marking the end of digit 7's slot

module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100_000 / 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_data,
  input  logic [7:0]  upd_dp,
  input  logic [7:0]  digit_en,
  input  logic [3:0]  bright,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [7:0]  AN,
  output logic        frame_tick
);

  localparam int unsigned SubW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SubW-1:0] SubLast = SubW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StGuard, StOn, StOff} phase_e;

  // Scan counters and per-slot phase
  logic [SubW-1:0] sub_q;
  logic [3:0]      step_q;
  logic [2:0]      dig_q;
  phase_e          phase_q;
  logic            en_q;
  logic [3:0]      bright_q;

  // Content registers and update handshake
  logic [31:0] disp_q, shadow_q;
  logic [7:0]  dpreg_q, shadow_dp_q;
  logic        pending_q, ready_q;

  // Registered outputs
  logic [7:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q, tick_q;

  logic       step_end, slot_start, slot_end, frame_end;
  logic [3:0] bright_cur;
  logic [4:0] nib_lsb;
  logic [3:0] nibble;
  logic       eligible, show;

  assign step_end   = (sub_q == SubLast);
  assign slot_start = (step_q == 4'd0) && (sub_q == '0);
  assign slot_end   = step_end && (step_q == 4'd15);
  assign frame_end  = slot_end && (dig_q == 3'd7);
  // With SCAN_DIV=1 the slot-start cycle is also the end of the guard step, so the live
  // brightness must steer the guard->on decision on that cycle.
  assign bright_cur = slot_start ? bright : bright_q;
  assign nib_lsb    = {dig_q, 2'b00};
  assign nibble     = disp_q[nib_lsb +: 4];

`ifdef SEGSCAN_LZB_EN
  logic [2:0] msn;
  always_comb begin
    msn = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (disp_q[4*i +: 4] != 4'd0) msn = 3'(i);
    end
  end
  assign eligible = (dig_q <= msn);
`else
  assign eligible = 1'b1;
`endif

  assign show = en_q & eligible;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan counters, slot phase FSM and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sub_q    <= '0;
      step_q   <= 4'd0;
      dig_q    <= 3'd0;
      phase_q  <= StGuard;
      en_q     <= 1'b0;
      bright_q <= 4'd0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      if (slot_start) begin
        en_q     <= digit_en[dig_q];
        bright_q <= bright;
      end

      if (step_end) begin
        sub_q  <= '0;
        step_q <= step_q + 4'd1;
        if (slot_end) dig_q <= dig_q + 3'd1;
        if (step_q == 4'd15) begin
          phase_q <= StGuard;
        end else begin
          case (phase_q)
            StGuard: phase_q <= (bright_cur != 4'd0) ? StOn : StOff;
            StOn:    if (step_q == bright_cur) phase_q <= StOff;
            default: phase_q <= phase_q;
          endcase
        end
      end else begin
        sub_q <= sub_q + SubW'(1);
      end

      // Outputs lag the counter/phase state by one cycle.
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      if (phase_q == StOn) begin
        seg_q <= hex_to_seg(nibble);
        dp_q  <= eligible ? ~dpreg_q[dig_q] : 1'b1;
        if (show) an_q <= ~(8'b1 << dig_q);
      end
      tick_q <= frame_end;
    end
  end

  // Update handshake: shadow holds one pending update until the frame boundary.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      disp_q      <= 32'd0;
      dpreg_q     <= 8'd0;
      shadow_q    <= 32'd0;
      shadow_dp_q <= 8'd0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      // ready_q implies !pending_q, so the two branches never compete.
      if (upd_valid && ready_q) begin
        shadow_q    <= upd_data;
        shadow_dp_q <= upd_dp;
        pending_q   <= 1'b1;
        ready_q     <= 1'b0;
      end else if (frame_end && pending_q) begin
        disp_q    <= shadow_q;
        dpreg_q   <= shadow_dp_q;
        pending_q <= 1'b0;
        ready_q   <= 1'b1;
      end
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_tick = tick_q;
  assign upd_ready  = ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4 (slot = 64 cycles, frame = 512).
// Cycle numbers count posedges since nRST release; outputs are sampled on the negedge.

module tb_seg7_scan_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_data;
  logic [7:0]  upd_dp;
  logic [7:0]  digit_en;
  logic [3:0]  bright;
  logic [6:0]  SEG;
  logic        DP;
  logic [7:0]  AN;
  logic        frame_tick;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc;

  seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_data   (upd_data),
    .upd_dp     (upd_dp),
    .digit_en   (digit_en),
    .bright     (bright),
    .SEG        (SEG),
    .DP         (DP),
    .AN         (AN),
    .frame_tick (frame_tick)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge CLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST      = 1'b0;
    upd_valid = 1'b0;
    upd_data  = 32'd0;
    upd_dp    = 8'd0;
    digit_en  = 8'hFF;
    bright    = 4'd15;
    repeat (3) @(negedge CLK);

    // Reset values
    check("rst_an", AN, 8'hFF);
    check("rst_seg", SEG, 7'h7F);
    check("rst_dp", DP, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_ready", upd_ready, 1'b1);
    nRST = 1'b1;

    // Queue 76543210 for the second frame
    goto(1);
    upd_data  = 32'h7654_3210;
    upd_dp    = 8'h08;
    upd_valid = 1'b1;
    goto(2);
    check("acc_ready_low", upd_ready, 1'b0);
    upd_valid = 1'b0;

    // First frame: display still 0
    goto(4);   check("guard_an", AN, 8'hFF);
    goto(5);   check("first_on_an", AN, 8'hFE);
               check("first_on_seg", SEG, 7'h40);
               check("first_on_dp", DP, 1'b1);
    goto(64);  check("on_end_an", AN, 8'hFE);
    goto(65);  check("off_an", AN, 8'hFF);
`ifdef SEGSCAN_LZB_EN
    goto(69);  check("lzb_d1_an", AN, 8'hFF);
    goto(197); check("lzb_d3_an", AN, 8'hFF);
`else
    goto(69);  check("d1_an", AN, 8'hFD);
    goto(197); check("old_d3_an", AN, 8'hF7);
               check("old_d3_seg", SEG, 7'h40);
`endif
    goto(500); check("pend_ready", upd_ready, 1'b0);
    goto(511); check("pre_tick", frame_tick, 1'b0);
    goto(512); check("tick1", frame_tick, 1'b1);
               check("ready_back", upd_ready, 1'b1);
`ifndef SEGSCAN_LZB_EN
               check("d7_last_an", AN, 8'h7F);
`endif
    goto(513); check("tick_pulse", frame_tick, 1'b0);

    // Second frame: new content
    goto(517); check("f2_d0_an", AN, 8'hFE);
               check("f2_d0_seg", SEG, 7'h40);
               check("f2_d0_dp", DP, 1'b1);
    goto(709); check("f2_d3_an", AN, 8'hF7);
               check("f2_d3_seg", SEG, 7'h30);
               check("f2_d3_dp", DP, 1'b0);
    goto(965); check("f2_d7_an", AN, 8'h7F);
               check("f2_d7_seg", SEG, 7'h78);

    // Brightness 0 then 1
    goto(1023); check("pre_tick2", frame_tick, 1'b0);
    goto(1024); check("tick2", frame_tick, 1'b1);
    bright = 4'd0;
    goto(1029); check("b0_an_a", AN, 8'hFF);
    goto(1060); check("b0_an_b", AN, 8'hFF);
    goto(1088); bright = 4'd1;
    goto(1092); check("b1_guard", AN, 8'hFF);
    goto(1093); check("b1_on_first", AN, 8'hFD);
    goto(1096); check("b1_on_last", AN, 8'hFD);
    goto(1097); check("b1_off", AN, 8'hFF);
    goto(1157); check("b1_d2_on", AN, 8'hFB);
    goto(1161); check("b1_d2_off", AN, 8'hFF);

    // Only digit 0 enabled
    goto(1536); bright = 4'd15; digit_en = 8'h01;
    goto(1541); check("en1_d0_an", AN, 8'hFE);
                check("en1_d0_seg", SEG, 7'h40);
    goto(1605); check("en1_d1_an", AN, 8'hFF);

    // Mid-frame update; second valid while pending must be ignored
    goto(1800); upd_data = 32'hDEAD_BEEF; upd_dp = 8'h00; upd_valid = 1'b1;
    goto(1801); check("upd2_ready_low", upd_ready, 1'b0);
                upd_data = 32'h1234_5678;
    goto(1900); check("upd2_hold_ready", upd_ready, 1'b0);
                upd_valid = 1'b0;
    goto(2047); check("pre_tick4", frame_tick, 1'b0);
    goto(2048); check("tick4", frame_tick, 1'b1);
                check("upd2_ready_back", upd_ready, 1'b1);
                digit_en = 8'hFF;
    goto(2053); check("f5_d0_an", AN, 8'hFE);
                check("f5_d0_seg", SEG, 7'h0E);
    goto(2100); upd_data = 32'h1111_1111; upd_valid = 1'b1;
    goto(2101); check("upd3_ready_low", upd_ready, 1'b0);
                upd_valid = 1'b0;
    goto(2117); check("f5_d1_an", AN, 8'hFD);
                check("f5_d1_seg", SEG, 7'h06);
    goto(2309); check("f5_d4_an", AN, 8'hEF);
                check("f5_d4_seg", SEG, 7'h21);
                check("f5_d4_dp", DP, 1'b1);

    // Asynchronous reset during digit 4 ON with an update pending
    goto(2314); check("pre_arst_an", AN, 8'hEF);
    #1 nRST = 1'b0;
    #1;
    check("arst_an", AN, 8'hFF);
    check("arst_seg", SEG, 7'h7F);
    check("arst_dp", DP, 1'b1);
    check("arst_ready", upd_ready, 1'b1);
    check("arst_tick", frame_tick, 1'b0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    goto(1);   upd_data = 32'h0000_0A05; upd_dp = 8'h00; upd_valid = 1'b1;
    goto(2);   upd_valid = 1'b0;
    goto(5);   check("rs_d0_an", AN, 8'hFE);
               check("rs_d0_seg", SEG, 7'h40);
    goto(517); check("lz_d0_an", AN, 8'hFE);
               check("lz_d0_seg", SEG, 7'h12);
    goto(581); check("lz_d1_an", AN, 8'hFD);
               check("lz_d1_seg", SEG, 7'h40);
    goto(600); upd_data = 32'h0000_0000; upd_valid = 1'b1;
    goto(601); upd_valid = 1'b0;
    goto(645); check("lz_d2_an", AN, 8'hFB);
               check("lz_d2_seg", SEG, 7'h08);
`ifdef SEGSCAN_LZB_EN
    goto(709);  check("lz_d3_blank", AN, 8'hFF);
    goto(1029); check("z_d0_an", AN, 8'hFE);
                check("z_d0_seg", SEG, 7'h40);
    goto(1093); check("z_d1_blank", AN, 8'hFF);
`else
    goto(709);  check("lz_d3_shown", AN, 8'hF7);
    goto(1029); check("z_d0_an", AN, 8'hFE);
                check("z_d0_seg", SEG, 7'h40);
    goto(1093); check("z_d1_shown", AN, 8'hFD);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
